// File: rtl/alu_iter_exec.sv
// Execute-stage ALU with a valid/ready handshake on both sides.
// Single-cycle logic/arith/compare ops; shifts iterate SHIFT_STEP bits per cycle.
module alu_iter_exec #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5,
    parameter int SHIFT_STEP  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            Operation,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  illegal,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    // A step wider than the largest shift amount simply finishes in one cycle.
    localparam int STEP_CAP = (SHIFT_STEP < (1 << SHAMT_WIDTH)) ? SHIFT_STEP : (1 << SHAMT_WIDTH) - 1;
    localparam logic [SHAMT_WIDTH-1:0] STEP_K = SHAMT_WIDTH'(STEP_CAP);

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic                    illegal_q, illegal_d;
    logic [SHAMT_WIDTH-1:0]  rem_q, rem_d;
    logic [1:0]              sop_q, sop_d;

    logic                    accept;
    logic                    is_shift;
    logic [SHAMT_WIDTH-1:0]  shamt;
    logic [SHAMT_WIDTH-1:0]  step_k;
    logic [DATA_WIDTH:0]     alu_out;

    // Returns {illegal, result}; shift codes return SrcA, which is the shamt==0 answer.
    function automatic logic [DATA_WIDTH:0] alu_op(input logic [3:0] op,
                                                   input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH-1:0] r;
        logic                  ill;
        r   = '0;
        ill = 1'b0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0011: r = a - b;
            4'b0100, 4'b0101, 4'b0111: r = a;
            4'b1000: r = {{(DATA_WIDTH-1){1'b0}}, (a == b)};
            4'b1001, 4'b1100: r = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'b1010: r = a ^ b;
            default: ill = 1'b1;
        endcase
        return {ill, r};
    endfunction

    // kind = Operation[1:0]: 00 SLL, 01 SRL, 11 SRA.
    function automatic logic [DATA_WIDTH-1:0] shift_by(input logic [1:0] kind,
                                                       input logic [DATA_WIDTH-1:0] v,
                                                       input logic [SHAMT_WIDTH-1:0] k);
        logic [DATA_WIDTH-1:0] r;
        case (kind)
            2'b00:   r = v << k;
            2'b01:   r = v >> k;
            default: r = $signed(v) >>> k;
        endcase
        return r;
    endfunction

    assign in_ready  = (state_q == IDLE) && !reset;
    assign accept    = in_valid && in_ready && !flush;
    assign is_shift  = (Operation == 4'b0100) || (Operation == 4'b0101) || (Operation == 4'b0111);
    assign shamt     = SrcB[SHAMT_WIDTH-1:0];
    assign step_k    = (rem_q < STEP_K) ? rem_q : STEP_K;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign ALUResult = result_q;
    assign illegal   = illegal_q;

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        rem_d     = rem_q;
        sop_d     = sop_q;
        alu_out   = alu_op(Operation, SrcA, SrcB);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    result_d  = alu_out[DATA_WIDTH-1:0];
                    illegal_d = alu_out[DATA_WIDTH];
                    if (is_shift && shamt != '0) begin
                        rem_d   = shamt;
                        sop_d   = Operation[1:0];
                        state_d = SHIFT;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SHIFT: begin
                result_d = shift_by(sop_q, result_q, step_k);
                rem_d    = rem_q - step_k;
                if (rem_q == step_k) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Abort wins over everything; the last visible result is left untouched.
        if (flush) begin
            state_d   = IDLE;
            illegal_d = 1'b0;
            result_d  = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            result_q  <= '0;
            illegal_q <= 1'b0;
            rem_q     <= '0;
            sop_q     <= '0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
            rem_q     <= rem_d;
            sop_q     <= sop_d;
        end
    end

endmodule
